spi_slave_if: RTL

- SPI slave front end that deserialises master frames into 10-bit words for the single-port RAM: 2 command bits plus 8 address/data bits, MSB first.
- Sits directly upstream of the RAM. Drives rx_data/rx_valid into it.
- For read-data frames, accepts the RAM's tx_data/tx_valid and serialises the byte back on MISO.
- SPI bit clock is the system clock clk: one MOSI bit is sampled per clk rising edge while SS_n is low.

---
 rtl/spi_slave_if_if.sv | 24 ++
 rtl/spi_slave_if.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the RAM-facing rx/tx handshake of the SPI slave front end.
// slave modport: the deserialiser itself; master modport: SPI master and RAM side.
// Plain wires only, no logic or storage.
interface spi_slave_if_if #(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave deserialiser: 10-bit {cmd,payload} frames to the RAM, read byte shifted back on MISO.
// Latency: rx_valid one cycle after the 10th MOSI sample; MISO MSB one cycle after tx_valid capture.
// No backpressure: the SPI master owns timing; FRAME_ERR_EN adds a frame_err pulse for aborted frames.
module spi_slave_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_slave_if_if.slave bus
`ifdef FRAME_ERR_EN
  ,
  output logic          frame_err
`endif
);
  localparam int FRAME_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_SMP  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] TX_DONE   = CNT_W'(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;          // MOSI bits sampled this frame, saturates at FRAME_W
  logic [FRAME_W-2:0] shift_q, shift_d;      // all but the last frame bit; the last comes straight from MOSI
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0]   tx_bits_q, tx_bits_d;  // 0: waiting for tx_valid, 1..DATA_W: bit on MISO, DATA_W+1: done
  logic               seen_q, seen_d;        // a read-address frame has been delivered
  logic               in_frame;
`ifdef FRAME_ERR_EN
  logic               ferr_q, ferr_d;
`endif

  assign in_frame = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);

  // Next-state: SS_n high always returns to IDLE; the command MSB picks the frame type.
  always_comb begin
    state_d = state_q;
    if (bus.SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CHK_CMD;
        CHK_CMD: begin
          if (!bus.MOSI)   state_d = WRITE;
          else if (seen_q) state_d = READ_DATA;
          else             state_d = READ_ADD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath: bit sampling, frame delivery, read-byte serialisation and abort clean-up.
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = 1'b0;
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    seen_d     = seen_q;
`ifdef FRAME_ERR_EN
    ferr_d     = 1'b0;
`endif
    if (bus.SS_n) begin
      cnt_d      = '0;
      tx_shift_d = '0;
      tx_bits_d  = '0;
      if (state_q == READ_DATA) seen_d = 1'b0;
`ifdef FRAME_ERR_EN
      ferr_d = ((cnt_q != '0) && (cnt_q < FRAME_CNT)) ||
               ((state_q == READ_DATA) && (tx_bits_q < TX_LAST));
`endif
    end else if (state_q == CHK_CMD) begin
      shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
      cnt_d   = CNT_ONE;
    end else if (in_frame) begin
      if (cnt_q < FRAME_CNT) begin
        shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_SMP) begin
          rx_data_d  = {shift_q, bus.MOSI};
          rx_valid_d = 1'b1;
          if (state_q == READ_ADD) seen_d = 1'b1;
        end
      end
      // Read byte is only accepted once the frame has been handed to the RAM.
      if ((state_q == READ_DATA) && (cnt_q == FRAME_CNT)) begin
        if (tx_bits_q == '0) begin
          if (bus.tx_valid) begin
            miso_d     = bus.tx_data[DATA_W-1];
            tx_shift_d = {bus.tx_data[DATA_W-2:0], 1'b0};
            tx_bits_d  = CNT_ONE;
          end
        end else if (tx_bits_q < TX_LAST) begin
          miso_d     = tx_shift_q[DATA_W-1];
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          tx_bits_d  = tx_bits_q + CNT_ONE;
        end else if (tx_bits_q == TX_LAST) begin
          tx_bits_d = TX_DONE;
          seen_d    = 1'b0;
        end
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      tx_shift_q <= '0;
      tx_bits_q  <= '0;
      seen_q     <= 1'b0;
`ifdef FRAME_ERR_EN
      ferr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      seen_q     <= seen_d;
`ifdef FRAME_ERR_EN
      ferr_q     <= ferr_d;
`endif
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.MISO     = miso_q;
`ifdef FRAME_ERR_EN
  assign frame_err    = ferr_q;
`endif
endmodule
